// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raster_pkg
//  Description : Shared types and constants for the rasterizer back end:
//                screen geometry, the buffered pixel record and the
//                pixel-writer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package raster_pkg;

    // Screen geometry of the frame buffer the rasterizer targets
    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int BYTES_PER_PIXEL = 4;

    // Field widths of a buffered pixel
    localparam int PIX_ADDR_W = 26;
    localparam int COLOR_W    = 24;

    // Only the three colour bytes of each 32-bit frame-buffer word are written
    localparam logic [3:0] AVM_BYTEENABLE = 4'b0111;

    // One pixel write as carried through the writer FIFO
    typedef struct packed {
        logic [PIX_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]    color;
    } pixel_t;

    // Drain-side state of the pixel writer
    typedef enum logic [0:0] {
        PW_IDLE  = 1'b0,
        PW_WRITE = 1'b1
    } pw_state_t;

    // Frame-buffer word layout: {pad, R, G, B}
    function automatic logic [31:0] pack_writedata(input logic [COLOR_W-1:0] color);
        return {8'h00, color};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Single-clock first-word-fall-through FIFO of pixel_t.
//                dout always shows the head entry when the FIFO is not
//                empty. Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 8     // power of 2, minimum 2
) (
    input  logic                    clock,
    input  logic                    reset,   // asynchronous, active-low
    input  logic                    push,
    input  logic                    pop,
    input  pixel_t                  din,
    output pixel_t                  dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    pixel_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_writer
//  Description : Accepts rasterizer pixel writes over valid/ready, buffers
//                them in a small FIFO and commits them to the frame buffer
//                through an Avalon-MM write master. Raises a one-cycle done
//                pulse once every pixel accepted up to tri_done is in memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_writer
    import raster_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,   // power of 2, minimum 2
    parameter int ADDR_W     = 26,  // pixel address width, at most PIX_ADDR_W
    parameter int BYTE_SHIFT = 2    // pixel index to byte address
) (
    input  logic                         clock,
    input  logic                         reset,          // asynchronous, active-low
    input  logic [ADDR_W-1:0]            pix_addr,
    input  logic [23:0]                  pix_color,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic                         tri_done,
    output logic                         done,
    output logic [ADDR_W+BYTE_SHIFT-1:0] avm_address,
    output logic [31:0]                  avm_writedata,
    output logic [3:0]                   avm_byteenable,
    output logic                         avm_write,
    input  logic                         avm_waitrequest,
    output logic [31:0]                  pixel_count
);

    localparam int AVM_AW = ADDR_W + BYTE_SHIFT;

    // FIFO interface
    pixel_t                       w_din;
    pixel_t                       w_head;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
    logic                         w_push;
    logic                         w_pop;

    // Handshake and drain qualifiers
    logic                         w_accept;
    logic                         w_commit;

    // Completion tracking
    logic                         w_done_req;
    logic                         w_quiet;
    logic                         w_done_fire;

    // Registered state and outputs
    pw_state_t                    r_state;
    logic                         r_write;
    logic [AVM_AW-1:0]            r_address;
    logic [31:0]                  r_writedata;
    logic [31:0]                  r_pixel_count;
    logic                         r_done_pending;
    logic                         r_done;

    // ------------------------------------------------------------------------
    // Accept side: ready follows the FIFO fill level directly, and is held low
    // while reset is asserted so nothing is taken before the FIFO is usable.
    // A pop in the same cycle never frees a full FIFO for a push.
    // ------------------------------------------------------------------------
    assign pix_ready = reset && !w_fifo_full;
    assign w_accept  = pix_valid && pix_ready;
    assign w_push    = w_accept;
    assign w_din     = {PIX_ADDR_W'(pix_addr), pix_color};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // ------------------------------------------------------------------------
    // Drain side: the output register is refilled from the FIFO head when it
    // is idle or when the write it holds is committing this cycle, which gives
    // one write per cycle while the slave keeps up.
    // ------------------------------------------------------------------------
    assign w_commit = (r_state == PW_WRITE) && !avm_waitrequest;
    assign w_pop    = !w_fifo_empty && ((r_state == PW_IDLE) || w_commit);

    // Write-master FSM; address and data only change when a new entry is popped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= PW_IDLE;
            r_write       <= 1'b0;
            r_address     <= '0;
            r_writedata   <= '0;
            r_pixel_count <= '0;
        end else begin
            case (r_state)
                PW_IDLE: begin
                    if (w_pop) begin
                        r_address   <= AVM_AW'(w_head.addr) << BYTE_SHIFT;
                        r_writedata <= pack_writedata(w_head.color);
                        r_write     <= 1'b1;
                        r_state     <= PW_WRITE;
                    end
                end
                PW_WRITE: begin
                    if (w_commit) begin
                        r_pixel_count <= r_pixel_count + 32'd1;
                        if (w_pop) begin
                            r_address   <= AVM_AW'(w_head.addr) << BYTE_SHIFT;
                            r_writedata <= pack_writedata(w_head.color);
                        end else begin
                            r_write <= 1'b0;
                            r_state <= PW_IDLE;
                        end
                    end
                end
                default: begin
                    r_write <= 1'b0;
                    r_state <= PW_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Completion: a triangle is finished once nothing is buffered and nothing
    // remains outstanding at the slave (idle, or the last write is committing
    // now). A tri_done that arrives with its own final pixel has to wait for
    // that pixel, so the request is held in done_pending until then. Further
    // tri_done pulses while pending fold into the same done.
    // ------------------------------------------------------------------------
    assign w_done_req  = r_done_pending || tri_done;
    assign w_quiet     = (w_fifo_count == '0) && ((r_state == PW_IDLE) || w_commit);
    assign w_done_fire = w_done_req && w_quiet && !(tri_done && w_accept);

    // Pending flag and one-cycle done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done_pending <= w_done_req && !w_done_fire;
            r_done         <= w_done_fire;
        end
    end

    assign avm_address    = r_address;
    assign avm_writedata  = r_writedata;
    assign avm_byteenable = AVM_BYTEENABLE;
    assign avm_write      = r_write;
    assign pixel_count    = r_pixel_count;
    assign done           = r_done;

endmodule
`default_nettype wire
